// File: rtl/mole_spawner_pkg.sv
// Shared types, constants and the target-selection helper for the mole spawner.
package mole_pkg;

    localparam int unsigned POS_W   = 4;
    localparam int unsigned ROUND_W = 6;

    localparam logic [POS_W-1:0] POS_NONE  = 4'd0;
    localparam logic [POS_W-1:0] POS_MAX   = 4'd9;
    localparam logic [15:0]      LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_t;

    // Map 4 random bits to 1..9 and step past the previous target so it never repeats.
    function automatic logic [POS_W-1:0] next_pos(input logic [3:0] rnd, input logic [POS_W-1:0] prev);
        logic [POS_W-1:0] cand;
        cand = (rnd % POS_MAX) + 4'd1;
        if (cand == prev) begin
            cand = (cand == POS_MAX) ? 4'd1 : cand + 4'd1;
        end
        return cand;
    endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Control/status bundle between the spawner and its game-side neighbours.
interface mole_spawner_if;
    import mole_pkg::*;

    logic               start;
    logic               hit;
    logic [POS_W-1:0]   pos;
    logic               busy;
    logic               done;
    logic               hit_pulse;
    logic               miss_pulse;
    logic [ROUND_W-1:0] round_cnt;
    logic [ROUND_W-1:0] hit_total;

    // Spawner side: consumes start/hit, drives target and status.
    modport master (
        input  start, hit,
        output pos, busy, done, hit_pulse, miss_pulse, round_cnt, hit_total
    );

    // Game side: issues start, forwards the judge's hit, observes status.
    modport slave (
        output start, hit,
        input  pos, busy, done, hit_pulse, miss_pulse, round_cnt, hit_total
    );

endinterface

// File: rtl/mole_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR; any game block needing random bits can reuse it.
module lfsr16
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    // Right-shifting Galois step: feedback taps applied when the outgoing bit is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Game round sequencer: blank gap, then a show window at a random position, repeated ROUNDS times.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000,
    parameter int unsigned ROUNDS      = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    mole_spawner_if.master bus
);

    localparam int unsigned TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_t             state;
    logic [TW-1:0]      timer;
    logic [POS_W-1:0]   prev_pos;
    logic [15:0]        lfsr_q;
    logic [11:0]        lfsr_unused;
    logic [POS_W-1:0]   cand;
    logic [ROUND_W-1:0] round_nx;
    logic               last_round;
    logic               show_hit;
    logic               show_last;
    logic               gap_last;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Only the low nibble feeds target selection.
    assign lfsr_unused = lfsr_q[15:4];
    assign cand        = next_pos(lfsr_q[3:0], prev_pos);
    assign round_nx    = bus.round_cnt + 6'd1;
    assign last_round  = (round_nx == ROUND_W'(ROUNDS));
    // First SHOW cycle (timer 0) ignores hit: the judge can still be crediting the previous target.
    assign show_hit    = bus.hit && (timer != '0);
    assign show_last   = (timer == TW'(SHOW_CYCLES - 1));
    assign gap_last    = (timer == TW'(GAP_CYCLES - 1));

    // Round FSM with timer, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            prev_pos       <= POS_NONE;
            bus.pos        <= POS_NONE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.hit_pulse  <= 1'b0;
            bus.miss_pulse <= 1'b0;
            bus.round_cnt  <= '0;
            bus.hit_total  <= '0;
        end else begin
            bus.hit_pulse  <= 1'b0;
            bus.miss_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state         <= GAP;
                        timer         <= '0;
                        bus.pos       <= POS_NONE;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.round_cnt <= '0;
                        bus.hit_total <= '0;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state    <= SHOW;
                        timer    <= '0;
                        bus.pos  <= cand;
                        prev_pos <= cand;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SHOW: begin
                    if (show_hit || show_last) begin
                        timer         <= '0;
                        bus.pos       <= POS_NONE;
                        bus.round_cnt <= round_nx;
                        // Hit takes priority over a coincident timeout.
                        if (show_hit) begin
                            bus.hit_pulse <= 1'b1;
                            bus.hit_total <= bus.hit_total + 6'd1;
                        end else begin
                            bus.miss_pulse <= 1'b1;
                        end
                        if (last_round) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with a reference model of target selection.
module tb_mole_spawner;
    import mole_pkg::*;

    localparam int unsigned SHOW = 8;
    localparam int unsigned GAPC = 4;
    localparam int unsigned RNDS = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mole_spawner_if bus ();

    mole_spawner #(
        .SHOW_CYCLES (SHOW),
        .GAP_CYCLES  (GAPC),
        .ROUNDS      (RNDS),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Independent reference for mod-9 mapping plus anti-repeat step.
    function automatic logic [3:0] ref_next(input logic [3:0] rnd, input logic [3:0] prev);
        int c;
        c = int'(rnd);
        while (c >= 9) c -= 9;
        c += 1;
        if (c == int'(prev)) c = (c == 9) ? 1 : c + 1;
        return 4'(c);
    endfunction

    // Reference LFSR; m_used holds the value the DUT saw at the most recent edge.
    logic [15:0] m_lfsr;
    logic [15:0] m_used;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= SEED;
            m_used <= SEED;
        end else begin
            m_used <= m_lfsr;
            m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Monitor: every new target matches the model; pulses are exclusive and never back to back.
    logic [3:0] mon_prev_pos;
    logic [3:0] mon_last_pos;
    logic [3:0] mon_exp;
    logic       mon_last_pulse;
    always @(negedge clk) begin
        if (rst) begin
            mon_prev_pos   = 4'd0;
            mon_last_pos   = 4'd0;
            mon_last_pulse = 1'b0;
        end else begin
            if (bus.pos != 4'd0 && mon_last_pos == 4'd0) begin
                mon_exp = ref_next(m_used[3:0], mon_prev_pos);
                check("pos_value", 32'(bus.pos), 32'(mon_exp));
                check("pos_range", 32'(bus.pos >= 4'd1 && bus.pos <= 4'd9), 32'd1);
                check("pos_no_repeat", 32'(bus.pos != mon_prev_pos), 32'd1);
                mon_prev_pos = bus.pos;
            end
            if (bus.hit_pulse || bus.miss_pulse) begin
                check("pulse_exclusive", 32'(bus.hit_pulse && bus.miss_pulse), 32'd0);
                check("pulse_back_to_back", 32'(mon_last_pulse), 32'd0);
            end
            mon_last_pulse = bus.hit_pulse | bus.miss_pulse;
            mon_last_pos   = bus.pos;
        end
    end

    task automatic start_pulse();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    // Count cycles with pos==0 until a target shows (bounded).
    task automatic wait_show(output int n);
        n = 0;
        while (bus.pos == 4'd0 && n < 50) begin
            n++;
            tick(1);
        end
    endtask

    // Count cycles with a target shown until it clears (bounded).
    task automatic count_show(output int n);
        n = 0;
        while (bus.pos != 4'd0 && n < 50) begin
            n++;
            tick(1);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 200) begin
            n++;
            tick(1);
        end
        check("game_done_in_time", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int g_n;
        int s_n;
        logic [3:0] rnd;
        logic [3:0] prv;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.hit   = 1'b0;
        tick(3);

        // Reset state
        check("rst_pos",        32'(bus.pos),        32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_hit_pulse",  32'(bus.hit_pulse),  32'd0);
        check("rst_miss_pulse", 32'(bus.miss_pulse), 32'd0);
        check("rst_round_cnt",  32'(bus.round_cnt),  32'd0);
        check("rst_hit_total",  32'(bus.hit_total),  32'd0);
        rst = 1'b0;
        tick(2);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Target selection corner cases
        rnd = 4'd8;  prv = 4'd9;
        check("np_repeat9_wraps", 32'(next_pos(rnd, prv)), 32'd1);
        rnd = 4'd15; prv = 4'd0;
        check("np_rnd15", 32'(next_pos(rnd, prv)), 32'd7);
        rnd = 4'd15; prv = 4'd7;
        check("np_rnd15_repeat", 32'(next_pos(rnd, prv)), 32'd8);
        rnd = 4'd9;  prv = 4'd1;
        check("np_rnd9_repeat", 32'(next_pos(rnd, prv)), 32'd2);

        // Game with no hits: three timed-out windows
        start_pulse();
        check("t1_busy", 32'(bus.busy), 32'd1);
        for (int r = 1; r <= 3; r++) begin
            wait_show(g_n);
            check("t1_gap_len", 32'(g_n), 32'd4);
            count_show(s_n);
            check("t1_show_len", 32'(s_n), 32'd8);
            check("t1_miss_pulse", 32'(bus.miss_pulse), 32'd1);
            check("t1_hit_pulse",  32'(bus.hit_pulse),  32'd0);
            check("t1_round_cnt",  32'(bus.round_cnt),  32'(r));
        end
        check("t1_done",      32'(bus.done),      32'd1);
        check("t1_busy_end",  32'(bus.busy),      32'd0);
        check("t1_pos_end",   32'(bus.pos),       32'd0);
        check("t1_hit_total", 32'(bus.hit_total), 32'd0);

        // Hit on 3rd SHOW cycle, held stale into the gap
        start_pulse();
        check("t2_round_clr", 32'(bus.round_cnt), 32'd0);
        check("t2_done_clr",  32'(bus.done),      32'd0);
        wait_show(g_n);
        check("t2_gap_len", 32'(g_n), 32'd4);
        tick(2);
        bus.hit = 1'b1;
        tick(1);
        check("t2_hit_pulse",  32'(bus.hit_pulse),  32'd1);
        check("t2_miss_pulse", 32'(bus.miss_pulse), 32'd0);
        check("t2_pos_drop",   32'(bus.pos),        32'd0);
        check("t2_hit_total",  32'(bus.hit_total),  32'd1);
        check("t2_round_cnt",  32'(bus.round_cnt),  32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t2_stale_no_pulse", 32'(bus.hit_pulse), 32'd0);
        end
        bus.hit = 1'b0;

        // Hit only on first SHOW cycle is ignored
        wait_show(g_n);
        check("t3_gap_tail", 32'(g_n), 32'd1);
        bus.hit = 1'b1;
        tick(1);
        bus.hit = 1'b0;
        check("t3_first_hit_ignored", 32'(bus.hit_pulse), 32'd0);
        check("t3_pos_held", 32'(bus.pos != 4'd0), 32'd1);
        count_show(s_n);
        check("t3_show_rest", 32'(s_n), 32'd7);
        check("t3_miss_pulse", 32'(bus.miss_pulse), 32'd1);
        check("t3_hit_total",  32'(bus.hit_total),  32'd1);

        // Hit on the last SHOW cycle wins over timeout
        wait_show(g_n);
        tick(7);
        bus.hit = 1'b1;
        tick(1);
        bus.hit = 1'b0;
        check("t3_last_hit_pulse", 32'(bus.hit_pulse),  32'd1);
        check("t3_last_no_miss",   32'(bus.miss_pulse), 32'd0);
        check("t3_hit_total2",     32'(bus.hit_total),  32'd2);
        check("t3_round_cnt",      32'(bus.round_cnt),  32'd3);
        check("t3_done",           32'(bus.done),       32'd1);
        tick(1);
        check("t3_no_late_miss", 32'(bus.miss_pulse), 32'd0);

        // Restart from DONE, then start mid-SHOW has no effect
        start_pulse();
        check("t5_round_clr", 32'(bus.round_cnt), 32'd0);
        check("t5_hits_clr",  32'(bus.hit_total), 32'd0);
        check("t5_busy",      32'(bus.busy),      32'd1);
        wait_show(g_n);
        check("t5_gap_len", 32'(g_n), 32'd4);
        tick(2);
        start_pulse();
        check("t5_mid_busy",  32'(bus.busy),             32'd1);
        check("t5_mid_pos",   32'(bus.pos != 4'd0),      32'd1);
        check("t5_mid_round", 32'(bus.round_cnt),        32'd0);
        count_show(s_n);
        check("t5_show_rest", 32'(s_n), 32'd5);
        check("t5_miss",      32'(bus.miss_pulse), 32'd1);
        check("t5_round_cnt", 32'(bus.round_cnt),  32'd1);

        // Asynchronous reset mid-SHOW
        wait_show(g_n);
        tick(2);
        #2 rst = 1'b1;
        #1;
        check("t6_pos",        32'(bus.pos),        32'd0);
        check("t6_busy",       32'(bus.busy),       32'd0);
        check("t6_round_cnt",  32'(bus.round_cnt),  32'd0);
        check("t6_hit_total",  32'(bus.hit_total),  32'd0);
        check("t6_hit_pulse",  32'(bus.hit_pulse),  32'd0);
        check("t6_miss_pulse", 32'(bus.miss_pulse), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(3);
        check("t6_idle_busy", 32'(bus.busy), 32'd0);
        check("t6_idle_pos",  32'(bus.pos),  32'd0);

        // Long run: 1002 rounds, odd games hold hit high throughout
        for (int g = 0; g < 334; g++) begin
            bus.hit = (g % 2 == 1);
            start_pulse();
            wait_done();
            check("t4_round_cnt", 32'(bus.round_cnt), 32'd3);
            check("t4_hit_total", 32'(bus.hit_total), (g % 2 == 1) ? 32'd3 : 32'd0);
        end
        bus.hit = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
